pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Interlock and sequencing controller for the 5-stage CPU datapath (IF, RF, ALU, DM, WB); the datapath has no forwarding.
- Shadows the destination register of every in-flight instruction and stalls decode on RAW hazards.
- Squashes the wrong-path fetch after a taken BRA/JUMP, and freezes the front end while a multi-cycle MULF occupies the ALU.
- Drives hold/bubble/flush strobes into the datapath pipeline registers and the ProgramCounter.

Parameters:
- MULF_LAT, 3, ALU cycles consumed by MULF (opc 24); legal range 1..15.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state).
- id_valid  in  1  RF-stage latch holds a real instruction.
- id_opc  in  6  RF-stage opcode.
- id_rs1  in  5  RF-stage RS1 field.
- id_rs2  in  5  RF-stage RS2 field.
- id_rd  in  5  RF-stage RD field.
- branch_taken  in  1  datapath redirect (PC select) asserted this cycle.
- pc_hold  out  1  freeze the PC.
- id_hold  out  1  freeze the RF-stage latches.
- alu_hold  out  1  freeze the ALU-stage latches (MULF only).
- alu_bubble  out  1  load a NOP (opc 0) into the ALU stage.
- dm_bubble  out  1  load a NOP into the DM stage.
- if_flush  out  1  replace the fetched instruction with a NOP at the next edge.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_hold==1.

Behaviour:
- Opcode classes:
  - Writes RF: 1, 2, 4–20, 23, 24.
  - Destination field: RS2 for opcodes 4, 5, 15–20; RD otherwise.
  - Reads RS1: 1, 2, 3, 4, 6–15, 17–21, 23, 24.
  - Reads RS2: 1, 2, 3, 6–14, 23, 24.
  - Opcode 0 and undefined opcodes are NOPs: they read and write nothing.
  - Register 0 has no special treatment.
- Shadow scoreboard: three entries {v, dst[4:0]} for ALU, DM and WB. When neither frozen nor bubbled, RF→ALU→DM→WB shift each cycle. Entries without an RF write hold v=0.
- RAW hazard (combinational):
  - Condition: id_valid, and a source the opcode actually reads equals dst of any entry with v=1.
  - The hazard clears the cycle after the producer leaves WB.
  - Maximum RAW stall is 3 cycles.
- FSM states: RUN, MULF_BUSY, FLUSH. Priority: MULF_BUSY > RAW > branch.
- RUN:
  - On RAW: pc_hold=id_hold=alu_bubble=1 and the ALU scoreboard entry loads v=0. The state stays RUN.
  - On branch_taken with no RAW: if_flush=1, then go to FLUSH.
  - On issuing opc 24 with no RAW: load cnt=MULF_LAT-1. If cnt≠0 go to MULF_BUSY, else stay in RUN.
  - branch_taken is ignored while RAW is active, because Reg1 is stale.
- MULF_BUSY:
  - Asserts pc_hold=id_hold=alu_hold=dm_bubble=1.
  - The ALU entry is frozen; DM and WB keep shifting, with DM taking v=0.
  - cnt decrements each cycle; when cnt==1 the next state is RUN.
  - RAW and branch inputs are ignored in this state.
- FLUSH (exactly one cycle):
  - The squashed instruction now in RF is treated as invalid (no hazard check, no issue), and alu_bubble=1.
  - The state returns to RUN.
  - A branch_taken seen in FLUSH is ignored.
- stall_cnt increments on every cycle with pc_hold==1 and saturates at all-ones.
- All outputs are combinational from state, scoreboard and inputs, except stall_cnt, which is registered.
- Reset (asynchronous, reset==0):
  - State RUN, scoreboard v=0, cnt=0, stall_cnt=0.
  - All strobe outputs are 0 while reset is low.
  - A reset in the middle of a MULF or flush abandons it with no residual hold.

Decomposition:
- Shared package `cpu_isa_pkg`:
  - Opcode constants: OPC_NOP=0, ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, ..., MOVEI=16, BRA=21, JUMP=22, ADDF=23, MULF=24.
  - FSM state encoding.
  - Decode functions `writes_rf`, `dest_sel`, `reads_rs1`, `reads_rs2`.
- One sub-module, `hazard_scoreboard`: the 3-entry shadow pipeline plus match logic; it outputs `raw_hit`.
- The FSM, MULF counter and stall counter live in the top module.

Test Plan:
- ADD r3←r1,r2, then ADD r4←r3,r5 back-to-back → pc_hold=id_hold=alu_bubble=1 for exactly 3 cycles, then issue; stall_cnt=3.
- LOAD to RS2=7, then an instruction reading only RD=7 (MOVEI-type, no RS reads) → no stall; stall_cnt=0.
- BRA with branch_taken=1 and no hazard → if_flush=1 for 1 cycle, one FLUSH cycle with alu_bubble=1, the next instruction issues normally.
- MULF with MULF_LAT=3 → pc_hold=alu_hold=dm_bubble=1 for 2 cycles, then RUN; a dependent follower then sees a RAW stall until the MULF leaves WB.
- BRA reading r1 immediately after SUB r1, with branch_taken=1 pulsed during the stall → no flush until the hazard clears; flush occurs only on the post-stall branch_taken.
- reset driven to 0 in the middle of MULF_BUSY → all strobes 0 immediately, state RUN, stall_cnt=0; after release, an ADD issues with no stall.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions for the 5-stage CPU datapath (IF, RF, ALU, DM, WB):
// opcode constants, the hazard controller FSM encoding, the scoreboard entry
// layout and the opcode decode helpers used by the interlock logic.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam int OPC_W = 6;
    localparam int REG_W = 5;

    localparam logic [OPC_W-1:0] OPC_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OPC_ADD   = 6'd1;
    localparam logic [OPC_W-1:0] OPC_SUB   = 6'd2;
    localparam logic [OPC_W-1:0] OPC_STORE = 6'd3;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 6'd4;
    localparam logic [OPC_W-1:0] OPC_MOVE  = 6'd5;
    localparam logic [OPC_W-1:0] OPC_MOVEI = 6'd16;
    localparam logic [OPC_W-1:0] OPC_BRA   = 6'd21;
    localparam logic [OPC_W-1:0] OPC_JUMP  = 6'd22;
    localparam logic [OPC_W-1:0] OPC_ADDF  = 6'd23;
    localparam logic [OPC_W-1:0] OPC_MULF  = 6'd24;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MULF_BUSY = 2'd1,
        ST_FLUSH     = 2'd2
    } hz_state_e;

    typedef enum logic {
        DST_RD  = 1'b0,
        DST_RS2 = 1'b1
    } dest_sel_e;

    // Opcode 0 and every undefined opcode fall outside all of these sets,
    // so they neither read nor write the register file.
    function automatic logic writes_rf(input logic [OPC_W-1:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, [OPC_LOAD:6'd20], OPC_ADDF, OPC_MULF};
    endfunction

    // LOAD, MOVE and the immediate group 15..20 (MOVEI among them) carry
    // their destination in the RS2 field.
    function automatic dest_sel_e dest_sel(input logic [OPC_W-1:0] opc);
        return (opc inside {OPC_LOAD, OPC_MOVE, [6'd15:6'd20]}) ? DST_RS2 : DST_RD;
    endfunction

    function automatic logic reads_rs1(input logic [OPC_W-1:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, OPC_STORE, OPC_LOAD, [6'd6:6'd15],
                           [6'd17:OPC_BRA], OPC_ADDF, OPC_MULF};
    endfunction

    function automatic logic reads_rs2(input logic [OPC_W-1:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, OPC_STORE, [6'd6:6'd14], OPC_ADDF, OPC_MULF};
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shadow copy of the destination register of the instructions sitting in the
// ALU, DM and WB stages, plus the RAW match against the RF-stage sources.
// Ports:
//   clk, reset      clock / asynchronous active-low reset (clears valid bits)
//   chk_en          RF instruction is real and the controller is checking it
//   issue           RF instruction moves into ALU this cycle
//   alu_freeze      ALU stage frozen (multi-cycle MULF); DM takes a bubble
//   id_opc/rs1/rs2/rd  RF-stage instruction fields
//   raw_hit         a source actually read matches a valid in-flight dst
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import cpu_isa_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             issue,
    input  logic             alu_freeze,
    input  logic [OPC_W-1:0] id_opc,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    output logic             raw_hit
);

    logic             alu_v_q, dm_v_q, wb_v_q;
    logic             alu_v_d, dm_v_d, wb_v_d;
    logic [REG_W-1:0] alu_dst_q, dm_dst_q, wb_dst_q;
    logic [REG_W-1:0] alu_dst_d, dm_dst_d, wb_dst_d;
    logic [REG_W-1:0] new_dst;
    logic             rs1_hit, rs2_hit;

    always_comb begin
        new_dst   = (dest_sel(id_opc) == DST_RS2) ? id_rs2 : id_rd;
        // Stage boundary RF -> ALU -> DM -> WB
        wb_v_d    = dm_v_q;
        wb_dst_d  = dm_dst_q;
        if (alu_freeze) begin
            alu_v_d   = alu_v_q;
            alu_dst_d = alu_dst_q;
            dm_v_d    = 1'b0;
            dm_dst_d  = dm_dst_q;
        end else begin
            alu_v_d   = issue & writes_rf(id_opc);
            alu_dst_d = new_dst;
            dm_v_d    = alu_v_q;
            dm_dst_d  = alu_dst_q;
        end
    end

    always_comb begin
        rs1_hit = reads_rs1(id_opc) &&
                  ((alu_v_q && alu_dst_q == id_rs1) ||
                   (dm_v_q  && dm_dst_q  == id_rs1) ||
                   (wb_v_q  && wb_dst_q  == id_rs1));
        rs2_hit = reads_rs2(id_opc) &&
                  ((alu_v_q && alu_dst_q == id_rs2) ||
                   (dm_v_q  && dm_dst_q  == id_rs2) ||
                   (wb_v_q  && wb_dst_q  == id_rs2));
        raw_hit = chk_en && (rs1_hit || rs2_hit);
    end

    // Only the valid bits need clearing; a dst field is ignored while v=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_v_q <= 1'b0;
            dm_v_q  <= 1'b0;
            wb_v_q  <= 1'b0;
        end else begin
            alu_v_q <= alu_v_d;
            dm_v_q  <= dm_v_d;
            wb_v_q  <= wb_v_d;
        end
    end

    always_ff @(posedge clk) begin
        alu_dst_q <= alu_dst_d;
        dm_dst_q  <= dm_dst_d;
        wb_dst_q  <= wb_dst_d;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Interlock and sequencing controller for the forwarding-less 5-stage
// datapath: RAW stalls on decode, wrong-path squash after a taken branch,
// and front-end freeze while a multi-cycle MULF occupies the ALU.
// Ports:
//   clk, reset              clock / asynchronous active-low reset
//   id_valid, id_opc, id_rs1, id_rs2, id_rd   RF-stage instruction
//   branch_taken            datapath redirect this cycle
//   pc_hold, id_hold        freeze PC / RF latches
//   alu_hold                freeze ALU latches (MULF)
//   alu_bubble, dm_bubble   inject NOP into ALU / DM
//   if_flush                squash the fetched instruction
//   stall_cnt               saturating count of pc_hold cycles (registered)
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
    import cpu_isa_pkg::*;
#(
    parameter int MULF_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opc,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             id_hold,
    output logic             alu_hold,
    output logic             alu_bubble,
    output logic             dm_bubble,
    output logic             if_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] CNT_INIT = 4'(MULF_LAT - 1);

    hz_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic raw_hit, chk_en, issue, alu_freeze;
    logic pc_hold_c, id_hold_c, alu_hold_c, alu_bubble_c, dm_bubble_c, if_flush_c;

    // Only RUN examines the RF instruction; FLUSH holds a squashed slot and
    // MULF_BUSY keeps the follower parked.
    assign chk_en = id_valid && (state_q == ST_RUN);

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .chk_en     (chk_en),
        .issue      (issue),
        .alu_freeze (alu_freeze),
        .id_opc     (id_opc),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .raw_hit    (raw_hit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        alu_freeze   = 1'b0;
        pc_hold_c    = 1'b0;
        id_hold_c    = 1'b0;
        alu_hold_c   = 1'b0;
        alu_bubble_c = 1'b0;
        dm_bubble_c  = 1'b0;
        if_flush_c   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (raw_hit) begin
                    // branch_taken is computed from a stale register here,
                    // so it is deliberately not looked at.
                    pc_hold_c    = 1'b1;
                    id_hold_c    = 1'b1;
                    alu_bubble_c = 1'b1;
                end else begin
                    issue = id_valid;
                    if (id_valid && id_opc == OPC_MULF) begin
                        cnt_d = CNT_INIT;
                    end
                    if (id_valid && id_opc == OPC_MULF && CNT_INIT != 4'd0) begin
                        state_d = ST_MULF_BUSY;
                    end else if (branch_taken) begin
                        if_flush_c = 1'b1;
                        state_d    = ST_FLUSH;
                    end
                end
            end
            ST_MULF_BUSY: begin
                alu_freeze  = 1'b1;
                pc_hold_c   = 1'b1;
                id_hold_c   = 1'b1;
                alu_hold_c  = 1'b1;
                dm_bubble_c = 1'b1;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                alu_bubble_c = 1'b1;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (pc_hold_c && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Strobes are forced low for the whole time reset is asserted.
    assign pc_hold    = reset & pc_hold_c;
    assign id_hold    = reset & id_hold_c;
    assign alu_hold   = reset & alu_hold_c;
    assign alu_bubble = reset & alu_bubble_c;
    assign dm_bubble  = reset & dm_bubble_c;
    assign if_flush   = reset & if_flush_c;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Directed scenarios with literal expectations, then randomized instruction
// traffic checked every cycle against a record-based pipeline model.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int LAT = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          id_valid = 1'b0;
    logic [5:0]    id_opc = '0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          branch_taken = 1'b0;
    logic          pc_hold, id_hold, alu_hold, alu_bubble, dm_bubble, if_flush;
    logic [CW-1:0] stall_cnt;

    pipeline_hazard_controller #(.MULF_LAT(LAT), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_opc       (id_opc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .pc_hold      (pc_hold),
        .id_hold      (id_hold),
        .alu_hold     (alu_hold),
        .alu_bubble   (alu_bubble),
        .dm_bubble    (dm_bubble),
        .if_flush     (if_flush),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Literal expectations posted by the driver, consumed at the next negedge.
    int            lit_n = 0;
    int            lit_sel [8];
    logic [CW-1:0] lit_exp [8];

    // Model: each in-flight RF writer and its stage (1=ALU, 2=DM, 3=WB).
    typedef struct {
        int         pos;
        logic [4:0] dst;
    } rec_t;
    rec_t inflight[$];
    int   m_mode = 0;   // 0 run, 1 multiply busy, 2 squash cycle
    int   m_left = 0;
    int   m_stall = 0;

    function automatic bit m_writes(input logic [5:0] o);
        return o inside {6'd1, 6'd2, [6'd4:6'd20], 6'd23, 6'd24};
    endfunction
    function automatic bit m_dst_rs2(input logic [5:0] o);
        return o inside {6'd4, 6'd5, [6'd15:6'd20]};
    endfunction
    function automatic bit m_rd1(input logic [5:0] o);
        return o inside {6'd1, 6'd2, 6'd3, 6'd4, [6'd6:6'd15], [6'd17:6'd21], 6'd23, 6'd24};
    endfunction
    function automatic bit m_rd2(input logic [5:0] o);
        return o inside {6'd1, 6'd2, 6'd3, [6'd6:6'd14], 6'd23, 6'd24};
    endfunction

    task automatic advance(input bit freeze_alu);
        rec_t nq[$];
        foreach (inflight[i]) begin
            rec_t r;
            r = inflight[i];
            if (!(freeze_alu && r.pos == 1)) r.pos = r.pos + 1;
            if (r.pos <= 3) nq.push_back(r);
        end
        inflight = nq;
    endtask

    function automatic logic [CW-1:0] pick(input int sel);
        case (sel)
            0:       return CW'(pc_hold);
            1:       return CW'(id_hold);
            2:       return CW'(alu_hold);
            3:       return CW'(alu_bubble);
            4:       return CW'(dm_bubble);
            5:       return CW'(if_flush);
            6:       return stall_cnt;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Single compare process: model expectations and posted literals.
    always @(negedge clk) begin
        bit   e_pc, e_id, e_ah, e_ab, e_db, e_fl, raw;
        rec_t nr;
        cyc++;
        e_pc = 0; e_id = 0; e_ah = 0; e_ab = 0; e_db = 0; e_fl = 0; raw = 0;
        if (!reset) begin
            inflight.delete();
            m_mode  = 0;
            m_left  = 0;
            m_stall = 0;
        end else if (m_mode == 1) begin
            e_pc = 1; e_id = 1; e_ah = 1; e_db = 1;
            advance(1'b1);
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end else if (m_mode == 2) begin
            e_ab = 1;
            advance(1'b0);
            m_mode = 0;
        end else begin
            if (id_valid) begin
                foreach (inflight[i]) begin
                    if ((m_rd1(id_opc) && id_rs1 == inflight[i].dst) ||
                        (m_rd2(id_opc) && id_rs2 == inflight[i].dst)) raw = 1;
                end
            end
            advance(1'b0);
            if (raw) begin
                e_pc = 1; e_id = 1; e_ab = 1;
            end else begin
                if (id_valid && m_writes(id_opc)) begin
                    nr.pos = 1;
                    nr.dst = m_dst_rs2(id_opc) ? id_rs2 : id_rd;
                    inflight.push_back(nr);
                end
                if (id_valid && id_opc == 6'd24 && LAT > 1) begin
                    m_mode = 1;
                    m_left = LAT - 1;
                end else if (branch_taken) begin
                    e_fl   = 1;
                    m_mode = 2;
                end
            end
        end
        check("pc_hold",    CW'(pc_hold),    CW'(e_pc));
        check("id_hold",    CW'(id_hold),    CW'(e_id));
        check("alu_hold",   CW'(alu_hold),   CW'(e_ah));
        check("alu_bubble", CW'(alu_bubble), CW'(e_ab));
        check("dm_bubble",  CW'(dm_bubble),  CW'(e_db));
        check("if_flush",   CW'(if_flush),   CW'(e_fl));
        check("stall_cnt",  stall_cnt,       CW'(m_stall));
        for (int k = 0; k < lit_n; k++) begin
            check($sformatf("lit_sig%0d", lit_sel[k]), pick(lit_sel[k]), lit_exp[k]);
        end
        if (reset && e_pc && m_stall < (1 << CW) - 1) m_stall++;
    end

    task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic br);
        @(posedge clk);
        #1;
        id_valid = v; id_opc = o; id_rs1 = a; id_rs2 = b; id_rd = d; branch_taken = br;
        lit_n = 0;
    endtask

    task automatic want(input int sel, input int val);
        lit_sel[lit_n] = sel;
        lit_exp[lit_n] = CW'(val);
        lit_n++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; id_valid = 1'b0; branch_taken = 1'b0; lit_n = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic       drv_hold;
    logic [5:0] r_opc;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Back-to-back ADD dependency: three stall cycles.
        do_reset();
        drive(1, 6'd1, 5'd1, 5'd2, 5'd3, 0); want(0, 0);
        drive(1, 6'd1, 5'd3, 5'd5, 5'd4, 0); want(0, 1); want(1, 1); want(3, 1);
        drive(1, 6'd1, 5'd3, 5'd5, 5'd4, 0); want(0, 1);
        drive(1, 6'd1, 5'd3, 5'd5, 5'd4, 0); want(0, 1); want(3, 1);
        drive(1, 6'd1, 5'd3, 5'd5, 5'd4, 0); want(0, 0); want(3, 0); want(6, 3);

        // LOAD writes RS2=7; MOVEI reads no source even with fields = 7.
        do_reset();
        drive(1, 6'd4, 5'd1, 5'd7, 5'd0, 0); want(0, 0);
        drive(1, 6'd16, 5'd7, 5'd7, 5'd7, 0); want(0, 0);
        drive(0, 6'd0, 5'd0, 5'd0, 5'd0, 0); want(6, 0);

        // Taken branch: one flush, one bubble cycle, then normal issue.
        do_reset();
        drive(1, 6'd21, 5'd9, 5'd0, 5'd0, 1); want(5, 1); want(0, 0);
        drive(1, 6'd1, 5'd1, 5'd2, 5'd3, 1); want(3, 1); want(5, 0);
        drive(1, 6'd1, 5'd1, 5'd2, 5'd3, 0); want(3, 0); want(0, 0);

        // MULF: two busy cycles, then dependent follower waits for WB exit.
        do_reset();
        drive(1, 6'd24, 5'd1, 5'd2, 5'd6, 0); want(0, 0);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 1); want(2, 1); want(4, 1);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 1); want(2, 1);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 1); want(2, 0); want(3, 1);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 1);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 1);
        drive(1, 6'd1, 5'd6, 5'd1, 5'd7, 0); want(0, 0); want(6, 5);

        // Branch taken during a RAW stall is ignored.
        do_reset();
        drive(1, 6'd2, 5'd2, 5'd3, 5'd1, 0);
        drive(1, 6'd21, 5'd1, 5'd0, 5'd0, 1); want(0, 1); want(5, 0);
        drive(1, 6'd21, 5'd1, 5'd0, 5'd0, 1); want(0, 1); want(5, 0);
        drive(1, 6'd21, 5'd1, 5'd0, 5'd0, 1); want(0, 1); want(5, 0);
        drive(1, 6'd21, 5'd1, 5'd0, 5'd0, 1); want(0, 0); want(5, 1);
        drive(1, 6'd1, 5'd4, 5'd5, 5'd6, 1); want(3, 1); want(5, 0);

        // Reset in the middle of MULF_BUSY.
        do_reset();
        drive(1, 6'd24, 5'd0, 5'd0, 5'd2, 0);
        drive(1, 6'd1, 5'd2, 5'd0, 5'd3, 0); want(2, 1);
        @(posedge clk);
        #1;
        reset = 1'b0; id_valid = 1'b1; branch_taken = 1'b1; lit_n = 0;
        for (int s = 0; s < 7; s++) want(s, 0);
        @(posedge clk);
        #1;
        reset = 1'b1; id_valid = 1'b1; id_opc = 6'd1; id_rs1 = 5'd2; id_rs2 = 5'd2;
        id_rd = 5'd3; branch_taken = 1'b0; lit_n = 0;
        want(0, 0); want(2, 0); want(4, 0);

        // Randomized traffic; a held RF instruction stays put.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drv_hold = id_hold;
            @(posedge clk);
            #1;
            lit_n = 0;
            reset = ($urandom_range(0, 299) != 0);
            if (!drv_hold) begin
                id_valid = ($urandom_range(0, 9) != 0);
                r_opc    = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 25));
                id_opc   = r_opc;
                id_rs1   = 5'($urandom_range(0, 3));
                id_rs2   = 5'($urandom_range(0, 3));
                id_rd    = 5'($urandom_range(0, 3));
            end
            branch_taken = ($urandom_range(0, 4) == 0) && (id_opc != 6'd24);
        end

        @(posedge clk);
        #1;
        lit_n = 0; reset = 1'b1; id_valid = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
